// File: rtl/pipe_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : pipe_event_monitor
// Purpose  : Event counters for the 5-stage MIPS pipeline. Counts enabled
//            cycles, RAW hazards against EX and MEM, ID stalls, EX flushes,
//            stores and stuck-PC entries. It also tracks the longest stall
//            run and raises a sticky stuck-PC flag. Counters are read
//            through a registered address/data port.
// Ports    : clk, rst (async, active-high), en (count enable), clr (sync
//            clear); regwriteE/writeregE, regwriteM/writeregM, rsD/rtD,
//            stallD, flushE, memwriteM, pcF (observed datapath);
//            rd_en/rd_addr -> rd_data/rd_valid (one-cycle read);
//            raw_pulse (RAW seen last cycle); stuck (sticky stuck-PC flag).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_event_monitor #(
  parameter int CNT_W       = 32,
  parameter int PC_W        = 32,
  parameter int STUCK_LIMIT = 8,
  parameter int SATURATE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             regwriteE,
  input  logic [4:0]       writeregE,
  input  logic             regwriteM,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             stallD,
  input  logic             flushE,
  input  logic             memwriteM,
  input  logic [PC_W-1:0]  pcF,
  input  logic             rd_en,
  input  logic [2:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             raw_pulse,
  output logic             stuck
);

  localparam int                C_SC_W     = $clog2(STUCK_LIMIT + 1);
  localparam logic [C_SC_W-1:0] C_LIMIT    = C_SC_W'(STUCK_LIMIT);
  localparam logic [C_SC_W-1:0] C_LIMIT_M1 = C_SC_W'(STUCK_LIMIT - 1);
  localparam logic [C_SC_W-1:0] C_SC_ONE   = C_SC_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0]  cnt_q [8];
  logic [CNT_W-1:0]  cnt_d [8];
  logic [CNT_W-1:0]  stall_run_q, stall_run_d;
  logic [C_SC_W-1:0] same_cnt_q, same_cnt_d;
  logic              stuck_q, stuck_d;
  logic              raw_pulse_q;
  logic [CNT_W-1:0]  rd_data_q;
  logic              rd_valid_q;
  logic [PC_W-1:0]   pc_prev_q;

  logic              raw_e;
  logic              raw_m;
  logic              pc_same;
  logic              stuck_entry;
  logic [6:0]        ev;
  logic [CNT_W-1:0]  run_inc;

  // A match on either source counts once; register 0 never creates a hazard.
  assign raw_e = regwriteE && (writeregE != 5'd0) &&
                 ((rsD == writeregE) || (rtD == writeregE));
  assign raw_m = regwriteM && (writeregM != 5'd0) &&
                 ((rsD == writeregM) || (rtD == writeregM));

  assign pc_same = (pcF == pc_prev_q);

  // Entry fires only on the LIMIT-1 -> LIMIT step, so a PC that stays stuck
  // is counted once until the PC moves and the run restarts.
  assign stuck_entry = en && pc_same && !stallD && (same_cnt_q == C_LIMIT_M1);

  // Event vector indexed by counter number (counter 7 is handled separately).
  assign ev = {stuck_entry, memwriteM, flushE, stallD, raw_m, raw_e, 1'b1};

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if ((SATURATE != 0) && (v == C_CNT_MAX)) begin
      return v;
    end
    return v + C_CNT_ONE;
  endfunction

  always_comb begin
    cnt_d       = cnt_q;
    stall_run_d = stall_run_q;
    same_cnt_d  = same_cnt_q;
    stuck_d     = stuck_q;
    run_inc     = (stall_run_q == C_CNT_MAX) ? stall_run_q : stall_run_q + C_CNT_ONE;

    if (clr) begin
      for (int i = 0; i < 8; i++) begin
        cnt_d[i] = '0;
      end
      stall_run_d = '0;
      same_cnt_d  = '0;
      stuck_d     = 1'b0;
    end else if (en) begin
      for (int i = 0; i < 7; i++) begin
        if (ev[i]) begin
          cnt_d[i] = bump(cnt_q[i]);
        end
      end

      if (stallD) begin
        stall_run_d = run_inc;
        if (run_inc > cnt_q[7]) begin
          cnt_d[7] = run_inc;
        end
      end else begin
        stall_run_d = '0;
      end

      // A stalled pipeline legitimately repeats the PC, so it neither
      // advances nor resets the repeat count.
      if (!pc_same) begin
        same_cnt_d = '0;
      end else if (!stallD && (same_cnt_q != C_LIMIT)) begin
        same_cnt_d = same_cnt_q + C_SC_ONE;
      end

      if (stuck_entry) begin
        stuck_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
      stall_run_q <= '0;
      same_cnt_q  <= '0;
      stuck_q     <= 1'b0;
      raw_pulse_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      pc_prev_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stall_run_q <= stall_run_d;
      same_cnt_q  <= same_cnt_d;
      stuck_q     <= stuck_d;
      raw_pulse_q <= en & (raw_e | raw_m);
      pc_prev_q   <= pcF;
      // Reads see the value held before this edge's update or clear.
      if (rd_en) begin
        rd_data_q  <= cnt_q[rd_addr];
        rd_valid_q <= 1'b1;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign raw_pulse = raw_pulse_q;
  assign stuck     = stuck_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_event_monitor
// Purpose  : Self-checking bench for pipe_event_monitor. Three instances share
//            one stimulus: 32-bit saturating, 4-bit wrapping and 4-bit
//            saturating. A behavioural model predicts all outputs each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_event_monitor;

  localparam int NDUT = 3;
  localparam int W   [NDUT] = '{32, 4, 4};
  localparam bit SATM[NDUT] = '{1'b1, 1'b0, 1'b1};
  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, clr = 1'b0;
  logic        regwriteE = 1'b0, regwriteM = 1'b0;
  logic [4:0]  writeregE = 5'd0, writeregM = 5'd0, rsD = 5'd0, rtD = 5'd0;
  logic        stallD = 1'b0, flushE = 1'b0, memwriteM = 1'b0;
  logic [31:0] pcF = 32'd0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_addr = 3'd0;

  wire [31:0] rd_data0;
  wire [3:0]  rd_data1, rd_data2;
  wire        rd_valid0, rd_valid1, rd_valid2;
  wire        raw0, raw1, raw2;
  wire        stuck0, stuck1, stuck2;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  bit pc_walk = 1'b0;

  always #5 clk = ~clk;

  pipe_event_monitor #(.CNT_W(32), .PC_W(32), .STUCK_LIMIT(LIM), .SATURATE(1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .regwriteE(regwriteE), .writeregE(writeregE),
    .regwriteM(regwriteM), .writeregM(writeregM),
    .rsD(rsD), .rtD(rtD), .stallD(stallD), .flushE(flushE),
    .memwriteM(memwriteM), .pcF(pcF), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .raw_pulse(raw0), .stuck(stuck0));

  pipe_event_monitor #(.CNT_W(4), .PC_W(32), .STUCK_LIMIT(LIM), .SATURATE(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .regwriteE(regwriteE), .writeregE(writeregE),
    .regwriteM(regwriteM), .writeregM(writeregM),
    .rsD(rsD), .rtD(rtD), .stallD(stallD), .flushE(flushE),
    .memwriteM(memwriteM), .pcF(pcF), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .raw_pulse(raw1), .stuck(stuck1));

  pipe_event_monitor #(.CNT_W(4), .PC_W(32), .STUCK_LIMIT(LIM), .SATURATE(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .regwriteE(regwriteE), .writeregE(writeregE),
    .regwriteM(regwriteM), .writeregM(writeregM),
    .rsD(rsD), .rtD(rtD), .stallD(stallD), .flushE(flushE),
    .memwriteM(memwriteM), .pcF(pcF), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .raw_pulse(raw2), .stuck(stuck2));

  // ---------------------------------------------------------------- model
  longint unsigned m_cnt [NDUT][8];
  longint unsigned m_sr  [NDUT];
  int              m_same[NDUT];
  bit              m_stuck[NDUT], m_rp[NDUT], m_rdv[NDUT];
  longint unsigned m_rdd [NDUT];
  logic [31:0]     m_pcprev;

  function automatic longint unsigned maxv(int k);
    return (64'd1 << W[k]) - 64'd1;
  endfunction

  function automatic longint unsigned bump(longint unsigned v, int k);
    if (v == maxv(k)) return SATM[k] ? v : 64'd0;
    return v + 64'd1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 8; i++) m_cnt[k][i] = 0;
      m_sr[k] = 0; m_same[k] = 0; m_stuck[k] = 0;
      m_rp[k] = 0; m_rdv[k] = 0; m_rdd[k] = 0;
    end
    m_pcprev = 32'd0;
  endtask

  task automatic model_step();
    bit re, rm, rep, entry;
    bit ev[7];
    re  = regwriteE && writeregE != 0 && (rsD == writeregE || rtD == writeregE);
    rm  = regwriteM && writeregM != 0 && (rsD == writeregM || rtD == writeregM);
    rep = (pcF == m_pcprev);
    for (int k = 0; k < NDUT; k++) begin
      if (rd_en) begin m_rdd[k] = m_cnt[k][rd_addr]; m_rdv[k] = 1; end
      else m_rdv[k] = 0;
      m_rp[k] = en && (re || rm);
      if (clr) begin
        for (int i = 0; i < 8; i++) m_cnt[k][i] = 0;
        m_sr[k] = 0; m_same[k] = 0; m_stuck[k] = 0;
      end else if (en) begin
        entry = rep && !stallD && (m_same[k] == LIM - 1);
        ev = '{1'b1, re, rm, stallD, flushE, memwriteM, entry};
        for (int i = 0; i < 7; i++) if (ev[i]) m_cnt[k][i] = bump(m_cnt[k][i], k);
        if (stallD) begin
          m_sr[k] = (m_sr[k] == maxv(k)) ? m_sr[k] : m_sr[k] + 1;
          if (m_sr[k] > m_cnt[k][7]) m_cnt[k][7] = m_sr[k];
        end else m_sr[k] = 0;
        if (!rep) m_same[k] = 0;
        else if (!stallD && m_same[k] < LIM) m_same[k] = m_same[k] + 1;
        if (entry) m_stuck[k] = 1;
      end
    end
    m_pcprev = pcF;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One compare process: every outputs of every instance, every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rd_data0", 64'(rd_data0), m_rdd[0]);
      chk("rd_data1", 64'(rd_data1), m_rdd[1]);
      chk("rd_data2", 64'(rd_data2), m_rdd[2]);
      chk("rd_valid0", 64'(rd_valid0), 64'(m_rdv[0]));
      chk("rd_valid1", 64'(rd_valid1), 64'(m_rdv[1]));
      chk("rd_valid2", 64'(rd_valid2), 64'(m_rdv[2]));
      chk("raw_pulse0", 64'(raw0), 64'(m_rp[0]));
      chk("raw_pulse1", 64'(raw1), 64'(m_rp[1]));
      chk("raw_pulse2", 64'(raw2), 64'(m_rp[2]));
      chk("stuck0", 64'(stuck0), 64'(m_stuck[0]));
      chk("stuck1", 64'(stuck1), 64'(m_stuck[1]));
      chk("stuck2", 64'(stuck2), 64'(m_stuck[2]));
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      if (pc_walk) pcF = pcF + 32'd4;
    end
  endtask

  task automatic rd(int idx, logic [63:0] exp, string name);
    rd_en = 1'b1; rd_addr = 3'(idx);
    @(negedge clk);
    rd_en = 1'b0;
    chk(name, 64'(rd_data0), exp);
  endtask

  task automatic clear_cycle();
    clr = 1'b1; cyc(1); clr = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #20;
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("reset_rd_valid", 64'(rd_valid0), 64'd0);
    chk("reset_stuck", 64'(stuck0), 64'd0);

    // 20 enabled idle cycles with a walking PC.
    pcF = 32'h1000; pc_walk = 1'b1;
    en = 1'b1; cyc(20); en = 1'b0;
    rd(0, 64'd20, "idle_cycles");
    chk("rd_valid_after_read", 64'(rd_valid0), 64'd1);
    for (int i = 1; i < 8; i++) rd(i, 64'd0, "idle_other");
    cyc(1);
    chk("rd_valid_drop", 64'(rd_valid0), 64'd0);

    // RAW against EX (both sources match) then against MEM with $0.
    clear_cycle();
    chk("raw_before", 64'(raw0), 64'd0);
    en = 1'b1; regwriteE = 1'b1; writeregE = 5'd8; rsD = 5'd8; rtD = 5'd8;
    cyc(1);
    chk("raw_pulse_hit", 64'(raw0), 64'd1);
    regwriteE = 1'b0; regwriteM = 1'b1; writeregM = 5'd0; rsD = 5'd0; rtD = 5'd0;
    cyc(1);
    chk("raw_pulse_one", 64'(raw0), 64'd0);
    regwriteM = 1'b0; writeregE = 5'd0; en = 1'b0;
    rd(1, 64'd1, "raw_e_count");
    rd(2, 64'd0, "raw_m_count");

    // Stall bursts of 3 and 5.
    clear_cycle();
    en = 1'b1;
    stallD = 1'b1; cyc(3);
    stallD = 1'b0; cyc(1);
    stallD = 1'b1; cyc(5);
    stallD = 1'b0; en = 1'b0;
    rd(3, 64'd8, "stall_cycles");
    rd(7, 64'd5, "max_stall_run");
    // Clear together with a stall and a read: read sees the pre-clear value.
    en = 1'b1; clr = 1'b1; stallD = 1'b1; rd_en = 1'b1; rd_addr = 3'd3;
    cyc(1);
    clr = 1'b0; stallD = 1'b0; en = 1'b0; rd_en = 1'b0;
    chk("read_during_clr", 64'(rd_data0), 64'd8);
    for (int i = 0; i < 8; i++) rd(i, 64'd0, "after_clr");

    // Stuck PC.
    pc_walk = 1'b0;
    clear_cycle();
    pcF = 32'h40; en = 1'b1;
    cyc(1);
    cyc(7);
    chk("stuck_7_repeats", 64'(stuck0), 64'd0);
    cyc(1);
    chk("stuck_8_repeats", 64'(stuck0), 64'd1);
    cyc(10); en = 1'b0;
    rd(6, 64'd1, "stuck_entries_1");
    en = 1'b1; pcF = 32'h44;
    cyc(9); en = 1'b0;
    rd(6, 64'd2, "stuck_entries_2");
    chk("stuck_sticky", 64'(stuck0), 64'd1);

    // Held PC under continuous stall is not stuck.
    clear_cycle();
    pcF = 32'h40; stallD = 1'b1; en = 1'b1;
    cyc(20);
    chk("stall_not_stuck", 64'(stuck0), 64'd0);
    stallD = 1'b0; en = 1'b0;

    // 17 stores: 4-bit wrap gives 1, 4-bit saturate gives 15.
    clear_cycle();
    memwriteM = 1'b1; en = 1'b1; cyc(17);
    memwriteM = 1'b0; en = 1'b0;
    rd(5, 64'd17, "stores_w32");
    chk("stores_wrap4", 64'(rd_data1), 64'd1);
    chk("stores_sat4", 64'(rd_data2), 64'd15);

    // Asynchronous reset in mid-cycle.
    en = 1'b1; rd_en = 1'b1; rd_addr = 3'd5;
    regwriteE = 1'b1; writeregE = 5'd3; rsD = 5'd3;
    cyc(3);
    chk("pre_reset_stuck", 64'(stuck0), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd_data", 64'(rd_data0), 64'd0);
    chk("async_rst_rd_valid", 64'(rd_valid0), 64'd0);
    chk("async_rst_raw", 64'(raw0), 64'd0);
    chk("async_rst_stuck", 64'(stuck0), 64'd0);
    #1 rst = 1'b0;
    regwriteE = 1'b0; rd_en = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      en        = ($urandom_range(0, 9) != 0);
      clr       = ($urandom_range(0, 59) == 0);
      regwriteE = 1'($urandom_range(0, 1));
      regwriteM = 1'($urandom_range(0, 1));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      rsD       = 5'($urandom_range(0, 3));
      rtD       = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) stallD = ~stallD;
      flushE    = 1'($urandom_range(0, 1));
      memwriteM = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) pcF = 32'h40 + 32'(4 * $urandom_range(0, 2));
      rd_en     = 1'($urandom_range(0, 1));
      rd_addr   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    chk_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
